mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl_pkg.sv | 10 +
 rtl/mdu_div_iter.sv | 51 +++++
 rtl/mdu_ctrl.sv | 91 +++++++++
 tb/tb_mdu_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared types and constants for the multiply/divide sequencer
package mdu_ctrl_pkg;
  typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;
  localparam int MDU_DIV_ITERS = 32;
  localparam logic [31:0] MDU_DIV0_QUO = 32'hFFFF_FFFF;
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: 32-step restoring divider with load/step/done handshake and sign fix-up
module mdu_div_iter
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);
  logic [31:0] rem_q, quo_q, dvs_q, rem_n, quo_n;
  logic [32:0] trial, diff;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;
  // quo/rem present the fixed-up result of the step in flight so the last step can be captured directly
  always_comb begin
    trial = {rem_q, quo_q[31]};
    diff  = trial - {1'b0, dvs_q};
    rem_n = diff[32] ? trial[31:0] : diff[31:0];
    quo_n = {quo_q[30:0], ~diff[32]};
    done  = step && cnt == 5'(MDU_DIV_ITERS - 1);
    quo   = neg_q ? -quo_n : quo_n;
    rem   = neg_r ? -rem_n : rem_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= abs32(a, sgn);
      dvs_q <= abs32(b, sgn);
      neg_q <= sgn & (a[31] ^ b[31]);
      neg_r <= sgn & a[31];
      cnt   <= '0;
    end else if (step) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt   <= cnt + 5'd1;
    end
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EXE-stage multiply/divide sequencer with stall, HI/LO write strobe and flush cancel
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_MDUStart,
  input  logic [1:0]  EXE_MDUOp,
  input  logic [31:0] EXE_SrcA,
  input  logic [31:0] EXE_SrcB,
  input  logic        EXE_Advance,
  input  logic        EXE_Flush,
  output logic        EXE_MDUBusy,
  output logic [31:0] EXE_HI,
  output logic [31:0] EXE_LO,
  output logic        EXE_HILOWr
);
  mdu_state_t  state, state_n;
  mdu_op_t     op;
  logic [1:0]  mul_cnt;
  logic [63:0] mul_q [MUL_LAT];
  logic [63:0] prod;
  logic [31:0] div_quo, div_rem, hi_n, lo_n;
  logic        accept, is_div, sgn, div0, mul_last, div_load, div_step, div_done, hilo_we;
  always_comb begin
    op       = mdu_op_t'(EXE_MDUOp);
    is_div   = op inside {MDU_DIV, MDU_DIVU};
    sgn      = op inside {MDU_MULT, MDU_DIV};
    accept   = state == IDLE && EXE_MDUStart && !EXE_Flush;
    div0     = is_div && EXE_SrcB == '0;
    mul_last = state == MUL && mul_cnt == 2'(MUL_LAT - 1);
    div_load = accept && is_div && !div0;
    div_step = state == DIV && !EXE_Flush;
    prod     = {{32{sgn & EXE_SrcA[31]}}, EXE_SrcA} * {{32{sgn & EXE_SrcB[31]}}, EXE_SrcB};
    state_n  = state;
    hilo_we  = 1'b0;
    hi_n     = mul_q[MUL_LAT-1][63:32];
    lo_n     = mul_q[MUL_LAT-1][31:0];
    if (EXE_Flush) state_n = IDLE;
    else if (accept) begin
      state_n = div0 ? DONE : is_div ? DIV : MUL;
      hilo_we = div0;
      hi_n    = div0 ? EXE_SrcA : hi_n;
      lo_n    = div0 ? MDU_DIV0_QUO : lo_n;
    end else if (mul_last) begin
      state_n = DONE;
      hilo_we = 1'b1;
    end else if (div_done) begin
      state_n = DONE;
      hilo_we = 1'b1;
      hi_n    = div_rem;
      lo_n    = div_quo;
    end else if (state == DONE && EXE_Advance) state_n = IDLE;
    EXE_MDUBusy = !EXE_Flush && ((state == IDLE && EXE_MDUStart) || state == MUL || state == DIV);
    EXE_HILOWr  = state == DONE && EXE_Advance && !EXE_Flush;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mul_cnt <= '0;
      EXE_HI  <= '0;
      EXE_LO  <= '0;
    end else begin
      state   <= state_n;
      mul_cnt <= (state == MUL && state_n == MUL) ? mul_cnt + 2'd1 : 2'd0;
      if (hilo_we) begin
        EXE_HI <= hi_n;
        EXE_LO <= lo_n;
      end
    end
  end
  // free-running product pipe fed from the Start cycle's operands; the tail lines up with DONE entry
  always_ff @(posedge clk) begin
    mul_q[0] <= prod;
    for (int i = 1; i < MUL_LAT; i++) mul_q[i] <= mul_q[i-1];
  end
  mdu_div_iter u_div (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .step (div_step),
    .sgn  (sgn),
    .a    (EXE_SrcA),
    .b    (EXE_SrcB),
    .done (div_done),
    .quo  (div_quo),
    .rem  (div_rem)
  );
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against an arithmetic reference model
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  localparam int LAT = 2;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, adv = 1'b0, flush = 1'b0;
  logic [1:0]  mop = 2'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, wr;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_err = 0;
  mdu_ctrl #(.MUL_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .EXE_MDUStart (start),
    .EXE_MDUOp    (mop),
    .EXE_SrcA     (src_a),
    .EXE_SrcB     (src_b),
    .EXE_Advance  (adv),
    .EXE_Flush    (flush),
    .EXE_MDUBusy  (busy),
    .EXE_HI       (hi),
    .EXE_LO       (lo),
    .EXE_HILOWr   (wr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] e_hi, output logic [31:0] e_lo, output int lat);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == MDU_MULT || op == MDU_MULTU) begin
      p = (op == MDU_MULT) ? 64'(sa * sb) : ua * ub;
      e_hi = p[63:32];
      e_lo = p[31:0];
      lat = LAT + 1;
    end else if (b == 0) begin
      e_hi = a;
      e_lo = 32'hFFFF_FFFF;
      lat = 1;
    end else if (op == MDU_DIV) begin
      sq = sa / sb;
      sr = sa % sb;
      e_hi = sr[31:0];
      e_lo = sq[31:0];
      lat = 33;
    end else begin
      p = ua / ub;
      e_lo = p[31:0];
      p = ua % ub;
      e_hi = p[31:0];
      lat = 33;
    end
  endfunction
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit end_flush);
    logic [31:0] e_hi, e_lo;
    int lat;
    model(op, a, b, e_hi, e_lo, lat);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      start = 1'b1; adv = 1'b0; flush = 1'b0;
      mop   = (c == 0) ? op : 2'($urandom_range(3));
      src_a = (c == 0) ? a : $urandom;
      src_b = (c == 0) ? b : $urandom;
      #1;
      chk("busy", 64'(busy), 64'(c < lat));
      chk("wr_early", 64'(wr), 64'd0);
      if (c == lat) begin
        chk("hi", 64'(hi), 64'(e_hi));
        chk("lo", 64'(lo), 64'(e_lo));
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      adv = 1'b0;
      #1;
      chk("hold_busy", 64'(busy), 64'd0);
      chk("hold_wr", 64'(wr), 64'd0);
    end
    @(negedge clk);
    adv = 1'b1; flush = end_flush;
    #1;
    chk("strobe", 64'(wr), 64'(!end_flush));
    chk("busy_done", 64'(busy), 64'd0);
    chk("hi_hold", 64'(hi), 64'(e_hi));
    chk("lo_hold", 64'(lo), 64'(e_lo));
    @(negedge clk);
    start = 1'b0; adv = 1'b0; flush = 1'b0;
    #1;
    chk("wr_after", 64'(wr), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask
  initial begin
    logic [1:0] rop;
    logic [31:0] ra, rb;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
    run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(MDU_DIVU, 32'h8000_0000, 32'd3, 0, 1'b0);
    run_op(MDU_DIV, 32'd5, 32'd0, 0, 1'b0);
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(MDU_MULT, 32'h1234_5678, 32'h8765_4321, 3, 1'b0);
    run_op(MDU_DIVU, 32'd100, 32'd0, 1, 1'b1);
    // flush while the divider is at count 10, then a fresh divide must run its full course
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b1; mop = MDU_DIV; src_a = 32'd1000; src_b = 32'd7; flush = (c == 11);
      #1;
      chk(c == 11 ? "flush_busy" : "pre_flush_busy", 64'(busy), c == 11 ? 64'd0 : 64'd1);
      chk("flush_wr", 64'(wr), 64'd0);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("post_flush_busy", 64'(busy), 64'd0);
    chk("post_flush_wr", 64'(wr), 64'd0);
    run_op(MDU_DIVU, 32'd9, 32'd4, 0, 1'b0);
    // reset in the middle of a divide
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      start = 1'b1; mop = MDU_DIV; src_a = 32'hFFFF_0000; src_b = 32'd3;
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wr", 64'(wr), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    run_op(MDU_MULTU, 32'd7, 32'd6, 0, 1'b0);
    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(3));
      ra  = $urandom;
      rb  = ($urandom_range(7) == 0) ? 32'd0 : ($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(1000));
      run_op(rop, ra, rb, $urandom_range(2), $urandom_range(4) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
